// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

   // Fetch controller states (2-bit encoding, visible on the debug port).
   typedef enum logic [1:0] {
      FETCH_BOOT  = 2'b00,
      FETCH_RUN   = 2'b01,
      FETCH_FLUSH = 2'b10
   } fetch_state_e;

   // One prefetch buffer entry: the instruction word tagged with its PC.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   // addi x0,x0,0 -- idle value for the instruction data bus.
   localparam logic [31:0] INST_NOP      = 32'h0000_0013;
   localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

   // Force a fetch target onto a word boundary.
   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return pc & PC_ALIGN_MASK;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, inst} entries. Clear wins over push and pop;
// the head is presented combinationally (zero when empty, no bypass).
module fetch_fifo
   import fetch_unit_pkg::*;
#(
   parameter int  DEPTH = 4,
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_push,
   input  fetch_entry_t i_push_data,
   input  logic         i_pop,
   input  logic         i_clear,
   output fetch_entry_t o_head,
   output logic         o_full,
   output logic         o_empty,
   output logic [CW-1:0] o_count
);

   localparam int AW = $clog2(DEPTH);

   fetch_entry_t  r_mem [DEPTH];
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;
   logic          w_do_pop;

   assign o_empty  = (r_count == '0);
   assign o_full   = (r_count == CW'(DEPTH));
   assign o_count  = r_count;
   assign w_do_pop = i_pop && !o_empty;
   assign o_head   = o_empty ? '0 : r_mem[r_rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (i_clear) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push)   r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + CW'(i_push) - CW'(w_do_pop);
      end
   end

   // Entry storage; a push into a full FIFO with a same-cycle pop reuses the head slot.
   always_ff @(posedge clk) begin
      if (i_push && !i_clear) r_mem[r_wr_ptr] <= i_push_data;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited word fetches, in-order response
// tagging, prefetch buffering and redirect flush with stale-response drop.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits on ready, and while valid is high without
// ready the payload (imem_req_addr) is held. Only a redirect may withdraw a
// pending request. Responses have no backpressure and return in order.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic         clk,
   input  logic         rst,
   output logic         imem_req_valid,
   input  logic         imem_req_ready,
   output logic [31:0]  imem_req_addr,
   input  logic         imem_resp_valid,
   input  logic [31:0]  imem_resp_data,
   output logic         inst_valid,
   input  logic         inst_ready,
   output logic [31:0]  inst,
   output logic [31:0]  inst_pc,
   input  logic         redirect,
   input  logic [31:0]  redirect_pc,
   output fetch_state_e o_dbg_state
);

   localparam int            CW  = $clog2(DEPTH) + 1;
   localparam logic [CW:0]   LIM = (CW+1)'(DEPTH);

   fetch_state_e  r_state,       w_state_next;
   logic [31:0]   r_fetch_pc,    w_fetch_pc_next;
   logic [31:0]   r_resp_pc,     w_resp_pc_next;
   logic [CW-1:0] r_outstanding, w_outstanding_next;
   logic [CW-1:0] r_stale,       w_stale_next;

   logic [CW-1:0] w_fifo_count;
   logic          w_fifo_full;
   logic          w_fifo_empty;
   logic          w_fifo_push;
   logic          w_fifo_pop;
   logic          w_fifo_clear;
   fetch_entry_t  w_fifo_head;
   fetch_entry_t  w_push_entry;

   logic          w_credit_ok;
   logic          w_req_valid;
   logic          w_req_fire;
   logic [CW-1:0] w_stale_base;
   logic          w_resp_drop;

   // Buffered plus in-flight words may never exceed the FIFO size.
   assign w_credit_ok = ({1'b0, w_fifo_count} + {1'b0, r_outstanding}) < LIM;
   assign w_req_valid = (r_state == FETCH_RUN) && !redirect && w_credit_ok;
   assign w_req_fire  = w_req_valid && imem_req_ready;

   // On redirect the in-flight count becomes the stale count; a response
   // landing in the redirect cycle itself is dropped and not counted.
   assign w_stale_base = (r_state == FETCH_FLUSH) ? r_stale : r_outstanding;
   assign w_resp_drop  = imem_resp_valid && (w_stale_base != '0);

   assign w_push_entry = '{pc: r_resp_pc, inst: imem_resp_data};
   assign w_fifo_pop   = inst_valid && inst_ready;

   assign imem_req_valid = w_req_valid;
   assign imem_req_addr  = r_fetch_pc;
   assign inst_valid     = !w_fifo_empty;
   assign inst           = w_fifo_head.inst;
   assign inst_pc        = w_fifo_head.pc;
   assign o_dbg_state    = r_state;

   // State register together with the fetch/response PCs and credit counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= FETCH_BOOT;
         r_fetch_pc    <= RESET_PC;
         r_resp_pc     <= RESET_PC;
         r_outstanding <= '0;
         r_stale       <= '0;
      end else begin
         r_state       <= w_state_next;
         r_fetch_pc    <= w_fetch_pc_next;
         r_resp_pc     <= w_resp_pc_next;
         r_outstanding <= w_outstanding_next;
         r_stale       <= w_stale_next;
      end
   end

   // Next-state and FIFO control; redirect overrides every state.
   always_comb begin
      w_state_next       = r_state;
      w_fetch_pc_next    = r_fetch_pc;
      w_resp_pc_next     = r_resp_pc;
      w_outstanding_next = r_outstanding;
      w_stale_next       = r_stale;
      w_fifo_push        = 1'b0;
      w_fifo_clear       = 1'b0;
      if (redirect) begin
         w_fifo_clear       = 1'b1;
         w_fetch_pc_next    = align_pc(redirect_pc);
         w_resp_pc_next     = align_pc(redirect_pc);
         w_outstanding_next = '0;
         w_stale_next       = w_stale_base - CW'(w_resp_drop);
         w_state_next       = (w_stale_next != '0) ? FETCH_FLUSH : FETCH_RUN;
      end else begin
         case (r_state)
            FETCH_BOOT: w_state_next = FETCH_RUN;
            FETCH_RUN: begin
               if (w_req_fire) w_fetch_pc_next = r_fetch_pc + 32'd4;
               if (imem_resp_valid) begin
                  w_fifo_push    = 1'b1;
                  w_resp_pc_next = r_resp_pc + 32'd4;
               end
               w_outstanding_next = r_outstanding + CW'(w_req_fire) - CW'(imem_resp_valid);
            end
            FETCH_FLUSH: begin
               if (imem_resp_valid) begin
                  w_stale_next = r_stale - 1'b1;
                  if (r_stale == CW'(1)) w_state_next = FETCH_RUN;
               end
            end
            default: w_state_next = FETCH_BOOT;
         endcase
      end
   end

   // The credit check must keep every push away from a full FIFO.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
      !(w_fifo_push && !w_fifo_clear && w_fifo_full && !w_fifo_pop));

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst_n      (rst),
      .i_push     (w_fifo_push),
      .i_push_data(w_push_entry),
      .i_pop      (w_fifo_pop),
      .i_clear    (w_fifo_clear),
      .o_head     (w_fifo_head),
      .o_full     (w_fifo_full),
      .o_empty    (w_fifo_empty),
      .o_count    (w_fifo_count)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: bench-side memory with configurable latency, and a
// program-order model: after reset or a redirect to P the datapath must see
// P, P+4, ... with the memory word of each address, nothing else.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
   localparam int          DEPTH       = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         imem_req_valid;
   logic         imem_req_ready = 1'b0;
   logic [31:0]  imem_req_addr;
   logic         imem_resp_valid = 1'b0;
   logic [31:0]  imem_resp_data = INST_NOP;
   logic         inst_valid;
   logic         inst_ready = 1'b0;
   logic [31:0]  inst;
   logic [31:0]  inst_pc;
   logic         redirect = 1'b0;
   logic [31:0]  redirect_pc = 32'h0;
   fetch_state_e o_dbg_state;

   fetch_unit #(.RESET_PC(TB_RESET_PC), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_resp_valid(imem_resp_valid),
      .imem_resp_data (imem_resp_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .o_dbg_state    (o_dbg_state)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int           n_cmp = 0;
   int           n_bad = 0;
   int           cyc;
   int           mem_lat;
   logic [31:0]  exp_q[$];       // accepted fetches on the current path, not yet consumed
   logic [31:0]  mem_addr_q[$];  // memory pipeline: addresses in flight
   int           mem_due_q[$];   // cycle in which each response is driven
   logic [31:0]  exp_req_addr;
   bit           prev_stall;
   logic [31:0]  prev_addr;
   int           n_acc;
   int           n_pop;
   logic [31:0]  last_pop_pc;
   logic [31:0]  first_pop_pc;

   logic         s_req_valid;
   logic [31:0]  s_req_addr;
   logic         s_inst_valid;
   logic [31:0]  s_inst_pc;
   fetch_state_e s_state;

   // Contents of instruction memory: a distinct word per address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic do_reset(input int lat);
      rst             = 1'b0;
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = INST_NOP;
      inst_ready      = 1'b0;
      redirect        = 1'b0;
      redirect_pc     = 32'h0;
      repeat (2) @(negedge clk);
      mem_addr_q.delete();
      mem_due_q.delete();
      exp_q.delete();
      exp_req_addr = TB_RESET_PC;
      prev_stall   = 1'b0;
      cyc          = 0;
      n_acc        = 0;
      n_pop        = 0;
      mem_lat      = lat;
      rst          = 1'b1;
   endtask

   // One clock cycle: drive at the falling edge, observe 1 time unit later.
   task automatic step(input bit req_rdy, input bit ins_rdy, input bit redir,
                       input logic [31:0] rpc);
      logic [31:0] exp_pc;
      imem_req_ready = req_rdy;
      inst_ready     = ins_rdy;
      redirect       = redir;
      redirect_pc    = rpc;
      if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = mem_word(mem_addr_q.pop_front());
         void'(mem_due_q.pop_front());
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = INST_NOP;
      end
      #1;
      s_req_valid  = imem_req_valid;
      s_req_addr   = imem_req_addr;
      s_inst_valid = inst_valid;
      s_inst_pc    = inst_pc;
      s_state      = o_dbg_state;

      if (prev_stall) begin
         n_cmp++;
         if (imem_req_addr !== prev_addr) begin
            n_bad++;
            $display("FAIL addr_stable cyc=%0d: got %h expected %h", cyc, imem_req_addr, prev_addr);
         end
      end
      prev_stall = imem_req_valid && !req_rdy;
      prev_addr  = imem_req_addr;

      if (redir) begin
         n_cmp++;
         if (imem_req_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL req_in_redirect cyc=%0d: got %b expected 0", cyc, imem_req_valid);
         end
      end

      if (imem_req_valid && req_rdy) begin
         n_cmp++;
         if (imem_req_addr !== exp_req_addr) begin
            n_bad++;
            $display("FAIL req_addr cyc=%0d: got %h expected %h", cyc, imem_req_addr, exp_req_addr);
         end
         mem_addr_q.push_back(imem_req_addr);
         mem_due_q.push_back(cyc + mem_lat);
         exp_q.push_back(exp_req_addr);
         exp_req_addr = exp_req_addr + 32'd4;
         n_acc++;
         n_cmp++;
         if (exp_q.size() > DEPTH) begin
            n_bad++;
            $display("FAIL credit cyc=%0d: got %0d in flight, limit %0d", cyc, exp_q.size(), DEPTH);
         end
      end

      if (inst_valid && ins_rdy) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL pop_unexpected cyc=%0d: got pc %h, expected no instruction", cyc, inst_pc);
         end else begin
            exp_pc = exp_q.pop_front();
            if (inst_pc !== exp_pc || inst !== mem_word(exp_pc)) begin
               n_bad++;
               $display("FAIL inst cyc=%0d: got pc %h data %h expected pc %h data %h",
                        cyc, inst_pc, inst, exp_pc, mem_word(exp_pc));
            end
         end
         if (n_pop == 0) first_pop_pc = inst_pc;
         n_pop++;
         last_pop_pc = inst_pc;
      end

      if (redir) begin
         exp_q.delete();
         exp_req_addr = rpc & PC_ALIGN_MASK;
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      n_cmp += 6;
      if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL %s_req_valid: got %b expected 0", tag, imem_req_valid); end
      if (imem_req_addr !== TB_RESET_PC) begin n_bad++; $display("FAIL %s_req_addr: got %h expected %h", tag, imem_req_addr, TB_RESET_PC); end
      if (inst_valid !== 1'b0) begin n_bad++; $display("FAIL %s_inst_valid: got %b expected 0", tag, inst_valid); end
      if (inst !== 32'h0) begin n_bad++; $display("FAIL %s_inst: got %h expected 0", tag, inst); end
      if (inst_pc !== 32'h0) begin n_bad++; $display("FAIL %s_inst_pc: got %h expected 0", tag, inst_pc); end
      if (o_dbg_state !== FETCH_BOOT) begin n_bad++; $display("FAIL %s_state: got %0d expected BOOT", tag, o_dbg_state); end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b0;
      @(negedge clk);
      #1;
      check_reset_outputs("reset");
   endtask

   task automatic test_boot_latency();
      do_reset(1);
      for (int c = 0; c < 24; c++) begin
         step(1'b1, 1'b1, 1'b0, 32'h0);
         n_cmp++;
         if (s_inst_valid !== (c >= 3)) begin
            n_bad++;
            $display("FAIL boot_inst_valid c=%0d: got %b expected %b", c, s_inst_valid, (c >= 3));
         end
         if (c < 2) begin
            n_cmp++;
            if (s_req_valid !== (c == 1)) begin
               n_bad++;
               $display("FAIL boot_req_valid c=%0d: got %b expected %b", c, s_req_valid, (c == 1));
            end
         end
      end
      n_cmp++;
      if (n_pop != 21) begin n_bad++; $display("FAIL boot_throughput: got %0d pops expected 21", n_pop); end
   endtask

   task automatic test_stall();
      do_reset(1);
      for (int c = 0; c < 20; c++) step(1'b1, 1'b0, 1'b0, 32'h0);
      n_cmp += 4;
      if (n_acc != DEPTH) begin n_bad++; $display("FAIL stall_accepted: got %0d expected %0d", n_acc, DEPTH); end
      if (s_req_valid !== 1'b0) begin n_bad++; $display("FAIL stall_req_valid: got %b expected 0", s_req_valid); end
      if (s_inst_valid !== 1'b1) begin n_bad++; $display("FAIL stall_inst_valid: got %b expected 1", s_inst_valid); end
      if (s_inst_pc !== TB_RESET_PC) begin n_bad++; $display("FAIL stall_inst_pc: got %h expected %h", s_inst_pc, TB_RESET_PC); end
      for (int c = 0; c < 30; c++) step(1'b1, 1'b1, 1'b0, 32'h0);
      n_cmp++;
      if (n_pop < 20) begin n_bad++; $display("FAIL stall_resume: got %0d pops expected >= 20", n_pop); end
   endtask

   task automatic test_flush();
      int first;
      do_reset(3);
      for (int c = 0; c < 4; c++) step(1'b1, 1'b1, 1'b0, 32'h0);
      n_cmp++;
      if (n_acc != 3) begin n_bad++; $display("FAIL flush_outstanding: got %0d expected 3", n_acc); end
      step(1'b1, 1'b1, 1'b1, 32'h0000_0100);
      for (int c = 5; c < 7; c++) begin
         step(1'b1, 1'b1, 1'b0, 32'h0);
         n_cmp += 2;
         if (s_state !== FETCH_FLUSH) begin n_bad++; $display("FAIL flush_state c=%0d: got %0d expected FLUSH", c, s_state); end
         if (s_req_valid !== 1'b0) begin n_bad++; $display("FAIL flush_req_valid c=%0d: got %b expected 0", c, s_req_valid); end
      end
      step(1'b1, 1'b1, 1'b0, 32'h0);
      n_cmp += 3;
      if (s_state !== FETCH_RUN) begin n_bad++; $display("FAIL flush_exit_state: got %0d expected RUN", s_state); end
      if (s_req_valid !== 1'b1) begin n_bad++; $display("FAIL flush_exit_req_valid: got %b expected 1", s_req_valid); end
      if (s_req_addr !== 32'h100) begin n_bad++; $display("FAIL flush_exit_addr: got %h expected 00000100", s_req_addr); end
      first = -1;
      for (int c = 0; c < 12 && first < 0; c++) begin
         step(1'b1, 1'b1, 1'b0, 32'h0);
         if (n_pop > 0) first = cyc - 1;
      end
      n_cmp += 2;
      if (first != 11) begin n_bad++; $display("FAIL flush_first_valid_cycle: got %0d expected 11", first); end
      if (first_pop_pc !== 32'h100) begin n_bad++; $display("FAIL flush_first_pc: got %h expected 00000100", first_pop_pc); end
   endtask

   task automatic test_misaligned();
      int p0;
      do_reset(1);
      for (int c = 0; c < 6; c++) step(1'b1, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b1, 32'h0000_0103);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      n_cmp += 2;
      if (s_req_valid !== 1'b1) begin n_bad++; $display("FAIL misalign_req_valid: got %b expected 1", s_req_valid); end
      if (s_req_addr !== 32'h100) begin n_bad++; $display("FAIL misalign_addr: got %h expected 00000100", s_req_addr); end
      p0 = n_pop;
      for (int c = 0; c < 10 && n_pop == p0; c++) step(1'b1, 1'b1, 1'b0, 32'h0);
      n_cmp++;
      if (n_pop == p0 || last_pop_pc !== 32'h100) begin
         n_bad++;
         $display("FAIL misalign_inst_pc: got %h (pops %0d) expected 00000100", last_pop_pc, n_pop - p0);
      end
   endtask

   task automatic test_wrap();
      int p0;
      do_reset(1);
      for (int c = 0; c < 3; c++) step(1'b1, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
      p0 = n_pop;
      for (int c = 0; c < 12; c++) step(1'b1, 1'b1, 1'b0, 32'h0);
      n_cmp++;
      if (n_pop - p0 < 6 || last_pop_pc >= 32'h100) begin
         n_bad++;
         $display("FAIL wrap: got %0d pops last pc %h expected >= 6 pops past 0", n_pop - p0, last_pop_pc);
      end
   endtask

   task automatic test_random_ready();
      do_reset(2);
      for (int c = 0; c < 2000 && n_pop < 50; c++)
         step($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, 1'b0, 32'h0);
      n_cmp++;
      if (n_pop != 50) begin n_bad++; $display("FAIL random_ready_count: got %0d pops expected 50", n_pop); end
   endtask

   task automatic test_random_redirect();
      do_reset($urandom_range(1, 4));
      for (int c = 0; c < 400; c++)
         step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 15) == 0, $urandom);
      n_cmp++;
      if (n_pop < 20) begin n_bad++; $display("FAIL random_redirect_progress: got %0d pops expected >= 20", n_pop); end
   endtask

   task automatic test_reset_mid_flush();
      do_reset(4);
      for (int c = 0; c < 5; c++) step(1'b1, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b1, 1'b1, 32'h0000_0200);
      step(1'b1, 1'b1, 1'b0, 32'h0);
      n_cmp++;
      if (s_state !== FETCH_FLUSH) begin n_bad++; $display("FAIL midflush_state: got %0d expected FLUSH", s_state); end
      #2 rst = 1'b0;
      #1;
      check_reset_outputs("midflush");
      do_reset(1);
      for (int c = 0; c < 10; c++) step(1'b1, 1'b1, 1'b0, 32'h0);
      n_cmp++;
      if (n_pop == 0 || first_pop_pc !== TB_RESET_PC) begin
         n_bad++;
         $display("FAIL midflush_restart: got pc %h (pops %0d) expected %h", first_pop_pc, n_pop, TB_RESET_PC);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_boot_latency();
      test_stall();
      test_flush();
      test_misaligned();
      test_wrap();
      test_random_ready();
      test_random_redirect();
      test_reset_mid_flush();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
